// File: rtl/ddr2_client_master.sv
// Queues user commands and issues them one at a time to a DDR2 controller request/ack interface.
// Latency: response pulse one cycle after c_ack is sampled; cmd_ready deasserts only while the command FIFO is full.
module ddr2_client_master #(
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 1023
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_we,
    input  logic [25:0] cmd_addr,
    input  logic [63:0] cmd_wdata,
    output logic        rsp_valid,
    output logic        rsp_we,
    output logic [63:0] rsp_rdata,
    output logic        rsp_err,
    output logic [25:0] c_addr,
    output logic [63:0] c_data_in,
    input  logic [63:0] c_data_out,
    input  logic        c_rdy,
    input  logic        c_ack,
    output logic        c_rd_req,
    output logic        c_wr_req,
    output logic        busy
);
    localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam logic [AW:0]  DEPTH_C  = (AW+1)'(FIFO_DEPTH);
    localparam logic [15:0]  TMO_LAST = 16'(TIMEOUT - 1);

    typedef struct packed {
        logic        we;
        logic [25:0] addr;
        logic [63:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {IDLE, WAIT_RDY, REQ, RESP} state_t;

    cmd_t          mem_q [FIFO_DEPTH];
    cmd_t          head;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   count_q, count_d;
    logic          push, pop, done;
    state_t        state_q, state_d;
    logic [15:0]   tmo_q, tmo_d;
    logic          hold_we_q, hold_we_d;
    logic [25:0]   c_addr_q, c_addr_d;
    logic [63:0]   c_data_in_q, c_data_in_d;
    logic          c_rd_req_q, c_rd_req_d, c_wr_req_q, c_wr_req_d;
    logic          rsp_valid_q, rsp_valid_d, rsp_we_q, rsp_we_d, rsp_err_q, rsp_err_d;
    logic [63:0]   rsp_rdata_q, rsp_rdata_d;
    logic          cmd_ready_q, cmd_ready_d, busy_q, busy_d;

    assign head = mem_q[rd_ptr_q];
    assign push = cmd_valid && cmd_ready_q;
    assign pop  = (state_q == IDLE) && (count_q != '0);
    // Ack wins over a timeout landing in the same cycle.
    assign done = (state_q == REQ) && (c_ack || (tmo_q == TMO_LAST));

    // Payload storage needs no reset: only the pointers define validity.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= '{we: cmd_we, addr: cmd_addr, wdata: cmd_wdata};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            hold_we_q   <= 1'b0;
            c_addr_q    <= '0;
            c_data_in_q <= '0;
            c_rd_req_q  <= 1'b0;
            c_wr_req_q  <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_we_q    <= 1'b0;
            rsp_err_q   <= 1'b0;
            rsp_rdata_q <= '0;
            cmd_ready_q <= 1'b1;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            hold_we_q   <= hold_we_d;
            c_addr_q    <= c_addr_d;
            c_data_in_q <= c_data_in_d;
            c_rd_req_q  <= c_rd_req_d;
            c_wr_req_q  <= c_wr_req_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_we_q    <= rsp_we_d;
            rsp_err_q   <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
            cmd_ready_q <= cmd_ready_d;
            busy_q      <= busy_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (pop)   state_d = WAIT_RDY;
            WAIT_RDY: if (c_rdy) state_d = REQ;
            REQ:      if (done)  state_d = RESP;
            RESP:                state_d = IDLE;
            default:             state_d = IDLE;
        endcase
    end

    always_comb begin
        wr_ptr_d    = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
        tmo_d       = tmo_q;
        hold_we_d   = hold_we_q;
        c_addr_d    = c_addr_q;
        c_data_in_d = c_data_in_q;
        c_rd_req_d  = c_rd_req_q;
        c_wr_req_d  = c_wr_req_q;
        rsp_valid_d = 1'b0;
        rsp_we_d    = rsp_we_q;
        rsp_err_d   = rsp_err_q;
        rsp_rdata_d = rsp_rdata_q;
        case (state_q)
            IDLE: begin
                if (pop) begin
                    hold_we_d   = head.we;
                    c_addr_d    = head.addr;
                    c_data_in_d = head.wdata;
                end
            end
            WAIT_RDY: begin
                if (c_rdy) begin
                    c_wr_req_d = hold_we_q;
                    c_rd_req_d = !hold_we_q;
                    tmo_d      = '0;
                end
            end
            REQ: begin
                if (done) begin
                    c_wr_req_d  = 1'b0;
                    c_rd_req_d  = 1'b0;
                    rsp_valid_d = 1'b1;
                    rsp_we_d    = hold_we_q;
                    rsp_err_d   = !c_ack;
                    rsp_rdata_d = (c_ack && !hold_we_q) ? c_data_out : '0;
                end else begin
                    tmo_d = tmo_q + 16'd1;
                end
            end
            default: ;
        endcase
        cmd_ready_d = (count_d != DEPTH_C);
        busy_d      = (count_d != '0) || (state_d != IDLE);
    end

    assign cmd_ready = cmd_ready_q;
    assign busy      = busy_q;
    assign c_addr    = c_addr_q;
    assign c_data_in = c_data_in_q;
    assign c_rd_req  = c_rd_req_q;
    assign c_wr_req  = c_wr_req_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_we    = rsp_we_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_ddr2_client_master.sv
// Directed bench for ddr2_client_master: reset, write, read, FIFO full, ordering, timeout, stray ack, reset in REQ.
module tb_ddr2_client_master;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic        cmd_we = 1'b0;
    logic [25:0] cmd_addr = '0;
    logic [63:0] cmd_wdata = '0;
    logic        rsp_valid, rsp_we, rsp_err;
    logic [63:0] rsp_rdata;
    logic [25:0] c_addr;
    logic [63:0] c_data_in;
    logic [63:0] c_data_out = '0;
    logic        c_rdy = 1'b0;
    logic        c_ack = 1'b0;
    logic        c_rd_req, c_wr_req, busy;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [63:0] RD_MASK = 64'hC0DE_0000_0000_0000;
    logic        ord_we   [4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    logic [25:0] ord_addr [4] = '{26'h1000001, 26'h2000002, 26'h0300003, 26'h0040004};
    logic [63:0] ord_data [4] = '{64'h1111_0000_0000_0001, 64'h2222_0000_0000_0002,
                                  64'h3333_0000_0000_0003, 64'h4444_0000_0000_0004};

    always #5 clk = ~clk;

    ddr2_client_master #(.FIFO_DEPTH(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_we(rsp_we), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .c_addr(c_addr), .c_data_in(c_data_in), .c_data_out(c_data_out),
        .c_rdy(c_rdy), .c_ack(c_ack), .c_rd_req(c_rd_req), .c_wr_req(c_wr_req),
        .busy(busy)
    );

    task automatic push(input logic we, input logic [25:0] addr, input logic [63:0] data);
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = data;
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_req(output bit ok);
        int i = 0;
        ok = 1'b0;
        while (!ok && i < 20) begin
            if (c_rd_req || c_wr_req) ok = 1'b1;
            else begin i++; @(negedge clk); end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++;
        if ({c_rd_req, c_wr_req, rsp_valid, rsp_err, rsp_we, busy} !== 6'b0) begin
            n_fail++; $display("FAIL reset_ctrl: got %b want 000000", {c_rd_req, c_wr_req, rsp_valid, rsp_err, rsp_we, busy});
        end
        n_tests++;
        if ({rsp_rdata, c_addr, c_data_in} !== '0) begin
            n_fail++; $display("FAIL reset_data: rdata %h addr %h wdata %h want zero", rsp_rdata, c_addr, c_data_in);
        end
        n_tests++;
        if (cmd_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %b want 1", cmd_ready); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++;
        if ({cmd_ready, busy} !== 2'b10) begin n_fail++; $display("FAIL post_reset: ready/busy %b want 10", {cmd_ready, busy}); end
    endtask

    task automatic test_write();
        bit ok;
        c_rdy = 1'b1;
        push(1'b1, 26'h0ABCDEF, 64'h0123456789ABCDEF);
        wait_req(ok);
        n_tests++;
        if (!ok) begin n_fail++; $display("FAIL write_wait: no request got %b want 1", ok); end
        for (int k = 1; k <= 5; k++) begin
            n_tests++;
            if ({c_wr_req, c_rd_req} !== 2'b10 || c_addr !== 26'h0ABCDEF || c_data_in !== 64'h0123456789ABCDEF) begin
                n_fail++;
                $display("FAIL write_req_cyc%0d: wr/rd %b addr %h data %h want 10 0abcdef 0123456789abcdef",
                         k, {c_wr_req, c_rd_req}, c_addr, c_data_in);
            end
            if (k == 5) c_ack = 1'b1;
            @(negedge clk);
        end
        c_ack = 1'b0;
        n_tests++;
        if ({c_wr_req, rsp_valid, rsp_we, rsp_err} !== 4'b0110 || rsp_rdata !== 64'h0) begin
            n_fail++; $display("FAIL write_rsp: req/vld/we/err %b rdata %h want 0110 0", {c_wr_req, rsp_valid, rsp_we, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
        n_tests++;
        if ({rsp_valid, busy} !== 2'b00) begin n_fail++; $display("FAIL write_after: vld/busy %b want 00", {rsp_valid, busy}); end
    endtask

    task automatic test_read();
        bit ok;
        c_data_out = 64'h1111_2222_3333_4444;
        push(1'b0, 26'h0000400, 64'hFFFF_FFFF_FFFF_FFFF);
        wait_req(ok);
        n_tests++;
        if (!ok || {c_rd_req, c_wr_req} !== 2'b10 || c_addr !== 26'h0000400) begin
            n_fail++; $display("FAIL read_req: rd/wr %b addr %h want 10 0000400", {c_rd_req, c_wr_req}, c_addr);
        end
        c_ack = 1'b1; c_data_out = 64'hDEADBEEFCAFEF00D;
        @(negedge clk);
        c_ack = 1'b0; c_data_out = '0;
        n_tests++;
        if ({rsp_valid, rsp_we, rsp_err, c_rd_req, c_wr_req} !== 5'b10000 || rsp_rdata !== 64'hDEADBEEFCAFEF00D) begin
            n_fail++; $display("FAIL read_rsp: vld/we/err/rd/wr %b rdata %h want 10000 deadbeefcafef00d",
                               {rsp_valid, rsp_we, rsp_err, c_rd_req, c_wr_req}, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_fifo_full();
        int n_acc = 0;
        int n_rsp = 0;
        int n_req = 0;
        bit bad = 1'b0;
        c_rdy = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cmd_valid = 1'b1; cmd_we = i[0]; cmd_addr = 26'(i + 16); cmd_wdata = 64'(i);
            if (cmd_ready) n_acc++;
            @(negedge clk);
        end
        cmd_valid = 1'b0;
        n_tests++;
        if (n_acc != 5) begin n_fail++; $display("FAIL full_accepted: got %0d want 5", n_acc); end
        n_tests++;
        if ({cmd_ready, busy} !== 2'b01) begin n_fail++; $display("FAIL full_ready: ready/busy %b want 01", {cmd_ready, busy}); end
        repeat (5) begin
            if (c_rd_req || c_wr_req) bad = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL full_no_req: request seen %b want 0", bad); end
        c_rdy = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            c_ack = c_rd_req | c_wr_req;
            if (c_rd_req || c_wr_req) begin
                n_tests++;
                if (c_addr !== 26'(n_req + 16)) begin n_fail++; $display("FAIL full_order%0d: addr %h want %h", n_req, c_addr, 26'(n_req + 16)); end
                n_req++;
            end
            if (rsp_valid) begin
                n_tests++;
                if (rsp_we !== n_rsp[0]) begin n_fail++; $display("FAIL full_rsp%0d: we %b want %b", n_rsp, rsp_we, n_rsp[0]); end
                n_rsp++;
            end
            @(negedge clk);
        end
        c_ack = 1'b0;
        n_tests++;
        if (n_rsp != 5 || {cmd_ready, busy} !== 2'b10) begin
            n_fail++; $display("FAIL full_drain: rsp %0d ready/busy %b want 5 10", n_rsp, {cmd_ready, busy});
        end
    endtask

    task automatic test_back_to_back();
        int pi = 0;
        int qi = 0;
        int ri = 0;
        int j;
        logic [63:0] exp_rd;
        c_rdy = 1'b1;
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (pi < 4) begin
                cmd_valid = 1'b1; cmd_we = ord_we[pi]; cmd_addr = ord_addr[pi]; cmd_wdata = ord_data[pi];
                if (cmd_ready) pi++;
            end else begin
                cmd_valid = 1'b0;
            end
            if (c_rd_req || c_wr_req) begin
                j = (qi < 4) ? qi : 3;
                n_tests++;
                if ({c_wr_req, c_rd_req} !== {ord_we[j], !ord_we[j]} || c_addr !== ord_addr[j] ||
                    (ord_we[j] && c_data_in !== ord_data[j]) || qi >= 4) begin
                    n_fail++; $display("FAIL b2b_req%0d: wr/rd %b addr %h data %h want %b %h %h",
                                       qi, {c_wr_req, c_rd_req}, c_addr, c_data_in, {ord_we[j], !ord_we[j]}, ord_addr[j], ord_data[j]);
                end
                qi++;
            end
            c_ack = c_rd_req | c_wr_req;
            c_data_out = {38'h0, c_addr} ^ RD_MASK;
            if (rsp_valid) begin
                j = (ri < 4) ? ri : 3;
                exp_rd = ord_we[j] ? 64'h0 : ({38'h0, ord_addr[j]} ^ RD_MASK);
                n_tests++;
                if (ri >= 4 || rsp_we !== ord_we[j] || rsp_err !== 1'b0 || rsp_rdata !== exp_rd) begin
                    n_fail++; $display("FAIL b2b_rsp%0d: we %b err %b rdata %h want %b 0 %h", ri, rsp_we, rsp_err, rsp_rdata, ord_we[j], exp_rd);
                end
                ri++;
            end
            @(negedge clk);
        end
        c_ack = 1'b0; c_data_out = '0;
        n_tests++;
        if (ri != 4 || qi != 4) begin n_fail++; $display("FAIL b2b_count: rsp %0d req %0d want 4 4", ri, qi); end
    endtask

    task automatic test_timeout();
        bit ok;
        int cnt = 0;
        c_rdy = 1'b1; c_data_out = 64'h5555_AAAA_5555_AAAA;
        push(1'b0, 26'h1234567, 64'h0);
        wait_req(ok);
        while (c_rd_req && cnt < 20) begin cnt++; @(negedge clk); end
        n_tests++;
        if (cnt != 8) begin n_fail++; $display("FAIL tmo_len: req cycles %0d want 8", cnt); end
        n_tests++;
        if ({rsp_valid, rsp_err} !== 2'b11 || rsp_rdata !== 64'h0) begin
            n_fail++; $display("FAIL tmo_rsp: vld/err %b rdata %h want 11 0", {rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
        push(1'b1, 26'h0000123, 64'hFEED);
        wait_req(ok);
        n_tests++;
        if (!ok || c_wr_req !== 1'b1) begin n_fail++; $display("FAIL tmo_next_req: wr %b want 1", c_wr_req); end
        c_ack = 1'b1;
        @(negedge clk);
        c_ack = 1'b0;
        n_tests++;
        if ({rsp_valid, rsp_we, rsp_err} !== 3'b110) begin n_fail++; $display("FAIL tmo_next_rsp: vld/we/err %b want 110", {rsp_valid, rsp_we, rsp_err}); end
        @(negedge clk);
        push(1'b0, 26'h0000777, 64'h0);
        wait_req(ok);
        repeat (7) @(negedge clk);
        n_tests++;
        if (c_rd_req !== 1'b1) begin n_fail++; $display("FAIL tmo_cyc8_req: rd %b want 1", c_rd_req); end
        c_ack = 1'b1; c_data_out = 64'h0BAD_F00D_1234_5678;
        @(negedge clk);
        c_ack = 1'b0; c_data_out = '0;
        n_tests++;
        if ({rsp_valid, rsp_err} !== 2'b10 || rsp_rdata !== 64'h0BAD_F00D_1234_5678) begin
            n_fail++; $display("FAIL tmo_ack_prio: vld/err %b rdata %h want 10 0badf00d12345678", {rsp_valid, rsp_err}, rsp_rdata);
        end
        @(negedge clk);
    endtask

    task automatic test_stray_ack();
        bit ok;
        bit bad = 1'b0;
        c_rdy = 1'b0; c_ack = 1'b1;
        push(1'b1, 26'h0000555, 64'hABCD);
        repeat (4) begin
            if (rsp_valid || c_wr_req || c_rd_req) bad = 1'b1;
            @(negedge clk);
        end
        c_ack = 1'b0; c_rdy = 1'b1;
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL stray_ack: activity %b want 0", bad); end
        wait_req(ok);
        @(negedge clk);
        n_tests++;
        if (c_wr_req !== 1'b1 || rsp_valid !== 1'b0) begin n_fail++; $display("FAIL stray_hold: wr/vld %b want 10", {c_wr_req, rsp_valid}); end
        c_ack = 1'b1;
        @(negedge clk);
        c_ack = 1'b0;
        n_tests++;
        if ({rsp_valid, rsp_err} !== 2'b10) begin n_fail++; $display("FAIL stray_rsp: vld/err %b want 10", {rsp_valid, rsp_err}); end
        @(negedge clk);
    endtask

    task automatic test_reset_in_req();
        bit ok;
        bit bad = 1'b0;
        c_rdy = 1'b1;
        push(1'b1, 26'h0000AAA, 64'h1);
        wait_req(ok);
        push(1'b0, 26'h0000BBB, 64'h2);
        push(1'b1, 26'h0000CCC, 64'h3);
        n_tests++;
        if (c_wr_req !== 1'b1 || busy !== 1'b1) begin n_fail++; $display("FAIL rst_pre: wr/busy %b want 11", {c_wr_req, busy}); end
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({c_rd_req, c_wr_req, rsp_valid, busy, cmd_ready} !== 5'b00001) begin
            n_fail++; $display("FAIL rst_async: rd/wr/vld/busy/ready %b want 00001", {c_rd_req, c_wr_req, rsp_valid, busy, cmd_ready});
        end
        @(negedge clk);
        rst_n = 1'b1;
        repeat (10) begin
            if (rsp_valid || c_rd_req || c_wr_req || busy || !cmd_ready) bad = 1'b1;
            @(negedge clk);
        end
        n_tests++;
        if (bad) begin n_fail++; $display("FAIL rst_no_replay: activity %b want 0", bad); end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_fifo_full();
        test_back_to_back();
        test_timeout();
        test_stray_ack();
        test_reset_in_req();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
